fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch.sv | 114 +++++++++++
 tb/tb_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Types shared by the fetch unit: FSM states, the {pc, instr} buffer entry and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer holding {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; validity comes from count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues sequential reads, buffers responses in order, flushes stale ones on redirect.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fault_out
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_flight;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fault;
  entry_t        push_entry;
  entry_t        head;

  assign redirect_pc       = align_pc(redirect_pc_in);
  assign in_flight         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign outstanding_after = outstanding - CW'(mem_rsp_valid);

  // Every in-flight request owns a buffer slot, so a response can never overflow the buffer.
  assign mem_req_valid = rst_n && !redirect_valid_in && !fault && !fifo_full
                      && (in_flight < (CW + 1)'(DEPTH));
  assign mem_addr      = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push       = mem_rsp_valid && (state == RUN) && !redirect_valid_in;
  assign pop        = !fifo_empty && ready_in && !redirect_valid_in;
  assign push_entry = '{pc: rsp_pc, instr: mem_rsp_data};

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault <= 1'b0;
    else if (redirect_valid_in && (redirect_pc_in[1:0] != 2'b00))
      fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif
  assign fault_out = fault;

  // rsp_pc tracks the PC of the next response worth keeping; all requests since a redirect are sequential.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= align_pc(RESET_PC);
      rsp_pc      <= align_pc(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_after + CW'(req_fire);
      if (redirect_valid_in) begin
        pc      <= redirect_pc;
        rsp_pc  <= redirect_pc;
        discard <= outstanding_after;
        state   <= (outstanding_after != '0) ? FLUSH : RUN;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (push)     rsp_pc <= rsp_pc + 32'd4;
        if ((state == FLUSH) && mem_rsp_valid) begin
          discard <= discard - CW'(1);
          if (discard == CW'(1)) state <= RUN;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid_in),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign valid_out = !fifo_empty;
  assign instr_out = fifo_empty ? 32'h0 : head.instr;
  assign pc_out    = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: memory model with random latency, expected stream computed from PC/epoch bookkeeping.
module tb_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fault_out;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_addr          (mem_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .fault_out         (fault_out)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        rsp_q[$];
  logic [31:0] req_log[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0, last_due = 0, epoch = 0, buffered = 0;
  int          lat = 1, stale_cnt = 0, out_cnt = 0;
  logic [31:0] exp_req = RESET_PC, exp_pc = RESET_PC;
  bit          fault_m = 1'b0, prev_pending = 1'b0;
  bit          rdy_mem = 1'b1, rdy_out = 1'b1, redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        s_req_valid, s_valid_out, s_fault;
  logic [31:0] s_addr, s_pc_out;

  function automatic logic [31:0] model_instr(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the reference model past the next posedge.
  task automatic cycle();
    bit   present;
    req_t r;
    int   due;
    @(negedge clk);
    present = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    mem_rsp_valid = present;
    if (present) mem_rsp_data = model_instr(rsp_q[0].addr);
    else         mem_rsp_data = $urandom;
    mem_req_ready     = rdy_mem;
    ready_in          = rdy_out;
    redirect_valid_in = redir;
    redirect_pc_in    = redir ? redir_pc : $urandom;
    #1;
    s_req_valid = mem_req_valid;
    s_addr      = mem_addr;
    s_valid_out = valid_out;
    s_pc_out    = pc_out;
    s_fault     = fault_out;
    check("valid_out", valid_out, buffered > 0);
    check("fault_out", fault_out, fault_m);
    if (valid_out) begin
      check("pc_out", pc_out, exp_pc);
      check("instr_out", instr_out, model_instr(exp_pc));
    end
    if (mem_req_valid) begin
      check("mem_addr", mem_addr, exp_req);
      check("req_budget", (rsp_q.size() + buffered < DEPTH) && !redir && !fault_m, 1);
    end
    if (prev_pending && !redir && !fault_m) check("req_hold", mem_req_valid, 1);

    if (valid_out && rdy_out) begin
      exp_pc += 32'd4;
      buffered--;
      out_cnt++;
    end
    if (present) begin
      r = rsp_q.pop_front();
      if (r.epoch == epoch && !redir) buffered++;
      else stale_cnt++;
    end
    if (mem_req_valid && rdy_mem) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_q.push_back('{exp_req, due, epoch});
      req_log.push_back(exp_req);
      exp_req += 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
      exp_req  = redir_pc & 32'hFFFF_FFFC;
      exp_pc   = redir_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir_pc[1:0] != 2'b00) fault_m = 1'b1;
`endif
    end
    prev_pending = mem_req_valid && !rdy_mem;
    cyc++;
  endtask

  // Asynchronous assert mid-cycle; release just after a posedge so the next cycle is the first out of reset.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    ready_in = 1'b0;
    redirect_valid_in = 1'b0;
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_fault", fault_out, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc", pc_out, 0);
    rsp_q.delete();
    buffered = 0;
    exp_req = RESET_PC;
    exp_pc = RESET_PC;
    fault_m = 1'b0;
    prev_pending = 1'b0;
    last_due = cyc;
    epoch++;
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, st, oc;
    bit  found;

    do_reset(3);

    // Boot: 1-cycle memory, decode always ready.
    lat = 1; rdy_mem = 1; rdy_out = 1; redir = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) begin
        check("boot_first_req", s_req_valid, 1);
        check("boot_first_addr", s_addr, RESET_PC);
      end
      if (i == 1) check("boot_not_yet_valid", s_valid_out, 0);
      if (i == 2) begin
        check("boot_valid", s_valid_out, 1);
        check("boot_pc", s_pc_out, RESET_PC);
      end
    end
    check("boot_req_count", req_log.size() >= 3, 1);
    check("boot_req0", req_log[0], RESET_PC);
    check("boot_req1", req_log[1], RESET_PC + 32'd4);
    check("boot_req2", req_log[2], RESET_PC + 32'd8);

    // Decode stalls for 10 cycles, then drains.
    rdy_out = 0;
    repeat (10) cycle();
    check("stall_full_no_req", s_req_valid, 0);
    check("stall_valid_held", s_valid_out, 1);
    oc = out_cnt;
    rdy_out = 1;
    repeat (10) cycle();
    check("stall_drained", out_cnt - oc >= DEPTH + 1, 1);

    // Redirect with DEPTH requests outstanding.
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rsp_q.size() == DEPTH) found = 1;
      else cycle();
    end
    check("flush_setup_outstanding", found, 1);
    st = stale_cnt;
    redir = 1; redir_pc = 32'h0000_0100;
    cycle();
    redir = 0;
    for (int i = 0; i < 30 && !s_valid_out; i++) cycle();
    check("flush_valid_after", s_valid_out, 1);
    check("flush_first_pc", s_pc_out, 32'h0000_0100);
    check("flush_stale_count", stale_cnt - st, DEPTH);

    // Redirect coinciding with a response and a consumed head.
    lat = 1;
    repeat (4) cycle();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (buffered > 0 && rsp_q.size() > 0 && rsp_q[0].due <= cyc) found = 1;
      else cycle();
    end
    check("coincide_setup", found, 1);
    oc = out_cnt;
    redir = 1; redir_pc = 32'h0000_0200;
    cycle();
    redir = 0;
    check("coincide_head_taken", out_cnt - oc, 1);
    cycle();
    check("coincide_empty_next", s_valid_out, 0);
    repeat (6) cycle();

    // PC wrap at the top of the address space.
    idx = req_log.size();
    redir = 1; redir_pc = 32'hFFFF_FFFC;
    cycle();
    redir = 0;
    repeat (8) cycle();
    check("wrap_req_a", req_log[idx], 32'hFFFF_FFFC);
    check("wrap_req_b", req_log[idx + 1], 32'h0000_0000);

    // Random traffic with occasional (sometimes back-to-back) aligned redirects.
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 3);
      rdy_mem = ($urandom % 4) != 0;
      rdy_out = ($urandom % 3) != 0;
      if (redir) redir = ($urandom % 2) == 0;
      else       redir = ($urandom % 40) == 0;
      redir_pc = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    redir = 0;

    // Reset in the middle of traffic abandons everything in flight.
    rdy_mem = 1; rdy_out = 0; lat = 3;
    repeat (3) cycle();
    do_reset(2);
    rdy_out = 1;
    cycle();
    check("rerst_first_req", s_req_valid, 1);
    check("rerst_first_addr", s_addr, RESET_PC);
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 3);
      rdy_mem = ($urandom % 4) != 0;
      rdy_out = ($urandom % 3) != 0;
      cycle();
    end
    rdy_mem = 1; rdy_out = 1; lat = 1;
    repeat (4) cycle();

    // Misaligned redirect target.
    idx = req_log.size();
    redir = 1; redir_pc = 32'h0000_0102;
    cycle();
    redir = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("trap_fault", s_fault, 1);
      check("trap_no_req", s_req_valid, 0);
    end
`else
    repeat (6) cycle();
    check("misalign_req", req_log[idx], 32'h0000_0100);
    check("misalign_no_fault", s_fault, 0);
`endif

    check("progress", out_cnt > 300, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
